// File: rtl/cfi_response_ctrl.sv
// cfi_response_ctrl: CFI violation response FSM (log/halt/trap/timeout/fatal) with lockable config; CFI_VIOL_COUNTER_EN adds viol_cnt_o
module cfi_response_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,
  input  logic        cfg_mode_i,
  input  logic        cfg_lock_i,
  input  logic        violation_i,
  input  logic [63:0] viol_pc_i,
  input  logic        trap_ack_i,
  input  logic        clear_i,
  output logic        monitor_rst_o,
  output logic        commit_halt_o,
  output logic        trap_req_o,
  output logic [63:0] trap_tval_o,
  output logic        alarm_o,
  output logic [2:0]  state_o
`ifdef CFI_VIOL_COUNTER_EN
  ,
  output logic [CNT_W-1:0] viol_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, HALT = 3'd2, TRAP = 3'd3, WAIT_CLR = 3'd4, FATAL = 3'd5} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic lock, en_eff, mode_eff, viol, cap, mrst, halt, trq, alm;
  logic [TW-1:0] wcnt;
  always_comb begin
    viol = state == ARMED && violation_i;
    cap  = viol && mode_eff;
    mrst = state == IDLE || state == WAIT_CLR || (viol && !mode_eff);
    halt = state == HALT || state == TRAP || state == FATAL;
    trq  = state == TRAP;
    alm  = state == FATAL;
    nxt  = state;
    case (state)
      IDLE:     nxt = en_eff ? ARMED : IDLE;
      ARMED:    nxt = violation_i ? (mode_eff ? HALT : ARMED) : (en_eff ? ARMED : IDLE);
      HALT:     nxt = TRAP;
      TRAP:     nxt = trap_ack_i ? WAIT_CLR : (wcnt == TW'(TIMEOUT - 1) ? FATAL : TRAP);
      WAIT_CLR: nxt = clear_i ? ARMED : WAIT_CLR;
      FATAL:    nxt = FATAL;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      lock          <= 1'b0;
      en_eff        <= 1'b0;
      mode_eff      <= 1'b0;
      wcnt          <= '0;
      monitor_rst_o <= 1'b1;
      commit_halt_o <= 1'b0;
      trap_req_o    <= 1'b0;
      trap_tval_o   <= '0;
      alarm_o       <= 1'b0;
      state_o       <= 3'd0;
    end else begin
      state         <= nxt;
      lock          <= lock | cfg_lock_i;
      en_eff        <= lock ? en_eff : cfg_en_i;
      mode_eff      <= lock ? mode_eff : cfg_mode_i;
      wcnt          <= state == TRAP ? wcnt + 1'b1 : '0;
      trap_tval_o   <= cap ? viol_pc_i : trap_tval_o;
      monitor_rst_o <= mrst;
      commit_halt_o <= halt;
      trap_req_o    <= trq;
      alarm_o       <= alm;
      state_o       <= state;
    end
  end
`ifdef CFI_VIOL_COUNTER_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) viol_cnt_o <= '0;
    else if (viol && !(&viol_cnt_o)) viol_cnt_o <= viol_cnt_o + 1'b1;
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_cfi_response_ctrl.sv
// tb_cfi_response_ctrl: scoreboard bench for cfi_response_ctrl
module tb_cfi_response_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_en = 1'b0, cfg_mode = 1'b0, cfg_lock = 1'b0, violation = 1'b0, trap_ack = 1'b0, clear = 1'b0;
  logic [63:0] viol_pc = '0, trap_tval;
  logic monitor_rst, commit_halt, trap_req, alarm;
  logic [2:0] state;
`ifdef CFI_VIOL_COUNTER_EN
  logic [15:0] viol_cnt;
`endif
  int passed = 0, total = 0, cnt_exp = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  cfi_response_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_mode_i(cfg_mode), .cfg_lock_i(cfg_lock),
    .violation_i(violation), .viol_pc_i(viol_pc), .trap_ack_i(trap_ack), .clear_i(clear),
    .monitor_rst_o(monitor_rst), .commit_halt_o(commit_halt), .trap_req_o(trap_req),
    .trap_tval_o(trap_tval), .alarm_o(alarm), .state_o(state)
`ifdef CFI_VIOL_COUNTER_EN
    , .viol_cnt_o(viol_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic viol(input logic [63:0] pc, input logic enf);
    violation = 1'b1;
    viol_pc = pc;
    if (enf) sb.push_back(pc);
    cnt_exp++;
    cyc();
    violation = 1'b0;
  endtask
  task automatic expect_trap(input string tag);
    check({tag, "_req"}, trap_req, 1);
    check({tag, "_sb"}, sb.size(), 1);
    if (sb.size() != 0) check({tag, "_tval"}, trap_tval, sb.pop_front());
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_mrst"}, monitor_rst, 1);
    check({tag, "_halt"}, commit_halt, 0);
    check({tag, "_trq"}, trap_req, 0);
    check({tag, "_tval"}, trap_tval, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_state"}, state, 0);
`ifdef CFI_VIOL_COUNTER_EN
    check({tag, "_cnt"}, viol_cnt, 0);
`endif
  endtask
  initial begin
    cyc(2);
    check_reset("rst");
    rst = 1'b0;
    cfg_en = 1'b1;
    cfg_mode = 1'b1;
    cyc(3);
    check("arm_state", state, 1);
    check("arm_mrst", monitor_rst, 0);
    viol(64'h8000_0040, 1'b1);
    check("halt_early", commit_halt, 0);
    cyc();
    check("halt_state", state, 2);
    check("halt_out", commit_halt, 1);
    check("halt_trq", trap_req, 0);
    cyc();
    expect_trap("trap1");
    trap_ack = 1'b1;
    cyc();
    trap_ack = 1'b0;
    cyc();
    check("wclr_state", state, 4);
    check("wclr_halt", commit_halt, 0);
    check("wclr_trq", trap_req, 0);
    check("wclr_mrst", monitor_rst, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    check("rearm_state", state, 1);
    check("rearm_mrst", monitor_rst, 0);
    cfg_mode = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      viol(64'h100 + 64'(i), 1'b0);
      check("log_pulse_hi", monitor_rst, 1);
      cyc();
      check("log_pulse_lo", monitor_rst, 0);
      check("log_state", state, 1);
    end
    check("log_no_trap", sb.size(), 0);
`ifdef CFI_VIOL_COUNTER_EN
    check("log_cnt", viol_cnt, 64'(cnt_exp));
`endif
    cfg_mode = 1'b1;
    cyc();
    viol(64'h1234_5678_9abc_def0, 1'b1);
    cyc();
    check("to_halt", state, 2);
    cyc();
    expect_trap("trap2");
    cyc(63);
    check("to_still_trap", state, 3);
    cyc();
    check("to_state", state, 5);
    check("to_alarm", alarm, 1);
    check("to_halt_out", commit_halt, 1);
    check("to_trq", trap_req, 0);
    clear = 1'b1;
    trap_ack = 1'b1;
    cyc(2);
    clear = 1'b0;
    trap_ack = 1'b0;
    check("fatal_sticky", state, 5);
    check("fatal_alarm", alarm, 1);
    rst = 1'b1;
    cyc();
    cnt_exp = 0;
    check_reset("rst_fatal");
    rst = 1'b0;
    cfg_lock = 1'b1;
    cyc();
    cfg_lock = 1'b0;
    cfg_en = 1'b0;
    cfg_mode = 1'b0;
    cyc(3);
    check("lock_arm", state, 1);
    cyc(4);
    check("lock_hold", state, 1);
    viol(64'hdead_beef_0000_1000, 1'b1);
    cyc();
    check("lock_halt", state, 2);
    cyc();
    expect_trap("trap3");
    cyc(62);
    check("ack64_pre", state, 3);
    trap_ack = 1'b1;
    cyc();
    trap_ack = 1'b0;
    cyc();
    check("ack64_state", state, 4);
    check("ack64_alarm", alarm, 0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    viol(64'h0000_0000_cafe_f00d, 1'b1);
    cyc(2);
    expect_trap("trap4");
    rst = 1'b1;
    cyc();
    check_reset("rst_trap");
    rst = 1'b0;
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
